// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX-to-MEM inputs and MEM-to-WB outputs of the memory stage.
interface mem_stage_if;
  logic [31:0] ALU_Out;
  logic [31:0] RD2_2;
  logic [31:0] Instr_2;
  logic [31:0] PC_2;
  logic [31:0] PC4_2;
  logic        RegWrite_2;
  logic [31:0] Instr_3;
  logic [31:0] PC_3;
  logic [31:0] PC4_3;
  logic [31:0] ALU_Out_3;
  logic [31:0] DM_Out;
  logic        RegWrite_3;

  modport master (
    output ALU_Out, RD2_2, Instr_2, PC_2, PC4_2, RegWrite_2,
    input  Instr_3, PC_3, PC4_3, ALU_Out_3, DM_Out, RegWrite_3
  );

  modport slave (
    input  ALU_Out, RD2_2, Instr_2, PC_2, PC4_2, RegWrite_2,
    output Instr_3, PC_3, PC4_3, ALU_Out_3, DM_Out, RegWrite_3
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: EX/MEM register, byte-addressable data memory, load extension.
// Optional DM_DISPLAY_EN prints one line per committed store.
module mem_stage #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  mem_stage_if.slave   bus
);
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] instr_q, pc_q, pc4_q, alu_q, rd2_q;
  logic        rw_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0; pc_q <= '0; pc4_q <= '0; alu_q <= '0; rd2_q <= '0; rw_q <= 1'b0;
    end else if (flush) begin
      instr_q <= '0; pc_q <= '0; pc4_q <= '0; alu_q <= '0; rd2_q <= '0; rw_q <= 1'b0;
    end else if (!stall) begin
      instr_q <= bus.Instr_2;
      pc_q    <= bus.PC_2;
      pc4_q   <= bus.PC4_2;
      alu_q   <= bus.ALU_Out;
      rd2_q   <= bus.RD2_2;
      rw_q    <= bus.RegWrite_2;
    end
  end

  assign bus.Instr_3    = instr_q;
  assign bus.PC_3       = pc_q;
  assign bus.PC4_3      = pc4_q;
  assign bus.ALU_Out_3  = alu_q;
  assign bus.RegWrite_3 = rw_q;

  logic [31:0]      dm [DM_WORDS];
  logic [DM_AW-1:0] widx;
  logic [5:0]       op;
  logic [4:0]       byte_sh;
  logic [31:0]      rd_word;
  logic [31:0]      wr_word;
  logic             wr_en;
  logic [15:0]      half;
  logic [7:0]       byte_v;

  assign widx    = alu_q[DM_AW+1:2];
  assign op      = instr_q[31:26];
  assign byte_sh = {alu_q[1:0], 3'b000};
  assign rd_word = dm[widx];

  // Partial stores merge into the currently addressed word.
  always_comb begin
    wr_en   = 1'b0;
    wr_word = rd_word;
    case (op)
      OP_SW: begin
        wr_en   = 1'b1;
        wr_word = rd2_q;
      end
      OP_SH: begin
        wr_en = 1'b1;
        if (alu_q[1]) wr_word[31:16] = rd2_q[15:0];
        else          wr_word[15:0]  = rd2_q[15:0];
      end
      OP_SB: begin
        wr_en = 1'b1;
        wr_word[byte_sh +: 8] = rd2_q[7:0];
      end
      default: ;
    endcase
  end

  // A stalled store waits; a flush does not cancel the store already in MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
    end else if (wr_en && !stall) begin
      dm[widx] <= wr_word;
    end
  end

`ifdef DM_DISPLAY_EN
  always @(posedge clk) begin
    if (reset && wr_en && !stall)
      $display("@%h: *%h <= %h", pc_q, {alu_q[31:2], 2'b00}, wr_word);
  end
`endif

  always_comb begin
    half        = alu_q[1] ? rd_word[31:16] : rd_word[15:0];
    byte_v      = rd_word[byte_sh +: 8];
    bus.DM_Out  = rd_word;
    case (op)
      OP_LH:   bus.DM_Out = {{16{half[15]}}, half};
      OP_LHU:  bus.DM_Out = {16'h0000, half};
      OP_LB:   bus.DM_Out = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  bus.DM_Out = {24'h000000, byte_v};
      default: bus.DM_Out = rd_word;
    endcase
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - Directed and randomized checks of mem_stage against a byte-array reference model.
module tb_mem_stage;
  logic clk;
  logic reset;
  logic stall;
  logic flush;

  mem_stage_if bus();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] LW  = 32'h8C000000;
  localparam logic [31:0] LH  = 32'h84000000;
  localparam logic [31:0] LHU = 32'h94000000;
  localparam logic [31:0] LB  = 32'h80000000;
  localparam logic [31:0] LBU = 32'h90000000;
  localparam logic [31:0] SW  = 32'hAC000000;
  localparam logic [31:0] SH  = 32'hA4000000;
  localparam logic [31:0] SB  = 32'hA0000000;
  localparam logic [31:0] NOP = 32'h00000000;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mb [4096];
  logic [31:0] m_instr, m_pc, m_pc4, m_alu, m_rd2;
  logic        m_rw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] a);
    return int'(a % 32'd4096);
  endfunction

  function automatic logic [31:0] mload(input logic [5:0] op, input logic [31:0] a);
    int b;
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  by;
    b  = bidx(a) & ~3;
    w  = {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    h  = a[1] ? {mb[b+3], mb[b+2]} : {mb[b+1], mb[b]};
    by = mb[bidx(a)];
    case (op)
      6'b100001: return {{16{h[15]}}, h};
      6'b100101: return {16'h0, h};
      6'b100000: return {{24{by[7]}}, by};
      6'b100100: return {24'h0, by};
      default:   return w;
    endcase
  endfunction

  task automatic mstore(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = bidx(a) & ~3;
    case (op)
      6'b101011: begin mb[b] = d[7:0]; mb[b+1] = d[15:8]; mb[b+2] = d[23:16]; mb[b+3] = d[31:24]; end
      6'b101001: begin
        if (a[1]) begin mb[b+2] = d[7:0]; mb[b+3] = d[15:8]; end
        else      begin mb[b]   = d[7:0]; mb[b+1] = d[15:8]; end
      end
      6'b101000: mb[bidx(a)] = d[7:0];
      default: ;
    endcase
  endtask

  task automatic mreset();
    for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    m_instr = '0; m_pc = '0; m_pc4 = '0; m_alu = '0; m_rd2 = '0; m_rw = 1'b0;
  endtask

  task automatic compare_all();
    check("Instr_3",    bus.Instr_3,    m_instr);
    check("PC_3",       bus.PC_3,       m_pc);
    check("PC4_3",      bus.PC4_3,      m_pc4);
    check("ALU_Out_3",  bus.ALU_Out_3,  m_alu);
    check("RegWrite_3", {31'b0, bus.RegWrite_3}, {31'b0, m_rw});
    check("DM_Out",     bus.DM_Out,     mload(m_instr[31:26], m_alu));
  endtask

  // Called just after a falling edge: drive, advance the model, clock, then check.
  task automatic cycle(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic st, input logic fl);
    logic [31:0] pc;
    logic        rw;
    pc = $urandom & 32'hFFFFFFFC;
    rw = 1'($urandom_range(0, 1));
    bus.Instr_2 = ins; bus.ALU_Out = alu; bus.RD2_2 = rd2;
    bus.PC_2 = pc; bus.PC4_2 = pc + 32'd4; bus.RegWrite_2 = rw;
    stall = st; flush = fl;
    if (!st) mstore(m_instr[31:26], m_alu, m_rd2);
    if (fl) begin
      m_instr = '0; m_pc = '0; m_pc4 = '0; m_alu = '0; m_rd2 = '0; m_rw = 1'b0;
    end else if (!st) begin
      m_instr = ins; m_pc = pc; m_pc4 = pc + 32'd4; m_alu = alu; m_rd2 = rd2; m_rw = rw;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic [5:0] ops [9];
  logic [31:0] r_ins, r_alu, r_rd2, tmp;

  initial begin
    ops = '{6'b100011, 6'b100001, 6'b100101, 6'b100000, 6'b100100,
            6'b101011, 6'b101001, 6'b101000, 6'b001000};
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    bus.Instr_2 = '0; bus.ALU_Out = '0; bus.RD2_2 = '0;
    bus.PC_2 = '0; bus.PC4_2 = '0; bus.RegWrite_2 = 1'b0;
    mreset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;

    cycle(32'h8C010004, 32'd4, 32'd0, 1'b0, 1'b0);
    check("capture_instr", bus.Instr_3, 32'h8C010004);

    cycle(SW, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    cycle(LW, 32'h10, 32'd0, 1'b0, 1'b0);
    check("sw_lw", bus.DM_Out, 32'hDEADBEEF);

    cycle(SB, 32'h11, 32'h00000080, 1'b0, 1'b0);
    cycle(LB, 32'h11, 32'd0, 1'b0, 1'b0);
    check("lb", bus.DM_Out, 32'hFFFFFF80);
    cycle(LBU, 32'h11, 32'd0, 1'b0, 1'b0);
    check("lbu", bus.DM_Out, 32'h00000080);
    cycle(LW, 32'h10, 32'd0, 1'b0, 1'b0);
    check("sb_merge", bus.DM_Out, 32'hDEAD80EF);

    cycle(SH, 32'h22, 32'h0000F00D, 1'b0, 1'b0);
    cycle(LH, 32'h22, 32'd0, 1'b0, 1'b0);
    check("lh_hi", bus.DM_Out, 32'hFFFFF00D);
    cycle(LHU, 32'h22, 32'd0, 1'b0, 1'b0);
    check("lhu_hi", bus.DM_Out, 32'h0000F00D);
    cycle(LH, 32'h20, 32'd0, 1'b0, 1'b0);
    check("lh_lo", bus.DM_Out, 32'h00000000);
    cycle(LW, 32'h20, 32'd0, 1'b0, 1'b0);
    check("sh_merge", bus.DM_Out, 32'hF00D0000);

    cycle(SW, 32'h30, 32'h12345678, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(NOP, 32'h0, 32'h0, 1'b1, 1'b0);
      check("stall_nowrite", bus.DM_Out, 32'h00000000);
    end
    cycle(LW, 32'h30, 32'd0, 1'b0, 1'b0);
    check("stall_commit", bus.DM_Out, 32'h12345678);

    cycle(LW | 32'h1, 32'h40, 32'd0, 1'b1, 1'b1);
    check("flush_instr", bus.Instr_3, 32'h0);
    check("flush_rw", {31'b0, bus.RegWrite_3}, 32'h0);

    cycle(SW, 32'h00001010, 32'hCAFEF00D, 1'b0, 1'b0);
    cycle(LW, 32'h10, 32'd0, 1'b0, 1'b0);
    check("alias", bus.DM_Out, 32'hCAFEF00D);

    for (int n = 0; n < 400; n++) begin
      tmp   = $urandom;
      r_ins = {ops[$urandom_range(0, 8)], tmp[25:0]};
      if ($urandom_range(0, 3) != 0) r_alu = $urandom & 32'h3F;
      else                           r_alu = ($urandom & 32'hFFFFF000) | ($urandom & 32'h3F);
      r_rd2 = $urandom;
      cycle(r_ins, r_alu, r_rd2, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_instr", bus.Instr_3, 32'h0);
    check("rst_pc", bus.PC_3, 32'h0);
    check("rst_pc4", bus.PC4_3, 32'h0);
    check("rst_alu", bus.ALU_Out_3, 32'h0);
    check("rst_rw", {31'b0, bus.RegWrite_3}, 32'h0);
    check("rst_dm", bus.DM_Out, 32'h0);
    mreset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0; flush = 1'b0;
    cycle(LW, 32'h10, 32'd0, 1'b0, 1'b0);
    check("rst_dm_cleared", bus.DM_Out, 32'h0);
    cycle(LW, 32'h30, 32'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
